// File: rtl/lut_layer_engine_pkg.sv
// Shared types and size helpers for the LUT layer engine.
// No ports: state enum plus index/address/depth derivations.
package lut_layer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int idx_w(input int neurons);
      return $clog2(neurons);
   endfunction

   function automatic int addr_w(input int neurons, input int in_bits);
      return idx_w(neurons) + in_bits;
   endfunction

   function automatic int depth(input int neurons, input int in_bits);
      return 1 << addr_w(neurons, in_bits);
   endfunction

endpackage

// File: rtl/lut_layer_engine_if.sv
// Config, input-vector and output-vector handshakes of the engine.
// master = driver side (source/sink), slave = engine side.
interface lut_layer_engine_if
   import lut_layer_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1,
   parameter int NEURONS  = 4
);
   localparam int ADDR_W = addr_w(NEURONS, IN_BITS);

   logic                         cfg_we;
   logic [ADDR_W-1:0]            cfg_addr;
   logic [OUT_BITS-1:0]          cfg_data;
   logic                         cfg_ready;
   logic                         s_valid;
   logic                         s_ready;
   logic [NEURONS*IN_BITS-1:0]   s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic [NEURONS*OUT_BITS-1:0]  m_data;
   logic                         busy;

   modport master (
      output cfg_we, cfg_addr, cfg_data,
      output s_valid, s_data, m_ready,
      input  cfg_ready, s_ready, m_valid, m_data, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data,
      input  s_valid, s_data, m_ready,
      output cfg_ready, s_ready, m_valid, m_data, busy
   );

endinterface

// File: rtl/lut_layer_engine_ram.sv
// Shared truth-table store: one write port, one registered read port.
// Ports: clk, i_we/i_waddr/i_wdata write, i_raddr -> o_rdata (1 cycle).
module lut_table_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 1,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   (* ram_style = "distributed" *)
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/lut_layer_engine.sv
// Time-multiplexed LogicNets layer: one neuron per cycle from a shared LUT.
// Ports: clk, rst (sync, active-low), bus (cfg write, s_* in, m_* out, busy).
module lut_layer_engine
   import lut_layer_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1,
   parameter int NEURONS  = 4
) (
   input logic clk,
   input logic rst,
   lut_layer_engine_if.slave bus
);

   localparam int IDX_W  = idx_w(NEURONS);
   localparam int ADDR_W = addr_w(NEURONS, IN_BITS);
   localparam int DEPTH  = depth(NEURONS, IN_BITS);
   localparam int CNT_W  = $clog2(NEURONS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NEURONS);

   state_t                      r_state, w_next;
   logic [CNT_W-1:0]            r_idx;
   logic [NEURONS*IN_BITS-1:0]  r_in;
   logic [NEURONS*OUT_BITS-1:0] r_mdata;
   logic [IN_BITS-1:0]          w_slice;
   logic [ADDR_W-1:0]           w_raddr;
   logic [OUT_BITS-1:0]         w_rdata;
   logic w_we, w_accept;
   logic w_cfg_ready, w_s_ready, w_m_valid, w_busy;

   always_comb begin
      w_slice = '0;
      for (int n = 0; n < NEURONS; n++)
         if (r_idx == CNT_W'(n))
            w_slice = r_in[n*IN_BITS +: IN_BITS];
   end

   if (IDX_W == 0) begin : g_flat
      assign w_raddr = w_slice;
   end else begin : g_idx
      assign w_raddr = {r_idx[IDX_W-1:0], w_slice};
   end

   always_comb begin
      w_next      = r_state;
      w_we        = 1'b0;
      w_accept    = 1'b0;
      w_cfg_ready = 1'b0;
      w_s_ready   = 1'b0;
      w_m_valid   = 1'b0;
      w_busy      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cfg_ready = 1'b1;
            w_s_ready   = !bus.cfg_we;
            w_we        = bus.cfg_we;
            w_accept    = bus.s_valid && !bus.cfg_we;
            if (w_accept) w_next = EVAL;
         end
         EVAL: begin
            w_busy = 1'b1;
            // idx==NEURONS is the drain cycle for the last read
            if (r_idx == LAST) w_next = HOLD;
         end
         HOLD: begin
            w_busy    = 1'b1;
            w_m_valid = 1'b1;
            if (bus.m_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_mdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_in  <= bus.s_data;
            r_idx <= '0;
         end else if (r_state == EVAL && r_idx != LAST) begin
            r_idx <= r_idx + 1'b1;
         end
         // read data lags the issuing index by one
         if (r_state == EVAL)
            for (int n = 0; n < NEURONS; n++)
               if (r_idx == CNT_W'(n + 1))
                  r_mdata[n*OUT_BITS +: OUT_BITS] <= w_rdata;
      end
   end

   lut_table_ram #(
      .DEPTH (DEPTH),
      .WIDTH (OUT_BITS),
      .AW    (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (bus.cfg_addr),
      .i_wdata (bus.cfg_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign bus.cfg_ready = w_cfg_ready;
   assign bus.s_ready   = w_s_ready;
   assign bus.m_valid   = w_m_valid;
   assign bus.busy      = w_busy;
   assign bus.m_data    = r_mdata;

endmodule

// File: tb/tb_lut_layer_engine.sv
// Bench for lut_layer_engine: transaction-level model plus directed cases.
// No ports.
module tb_lut_layer_engine;
   import lut_layer_pkg::*;

   localparam int IN_BITS  = 8;
   localparam int OUT_BITS = 1;
   localparam int NEURONS  = 4;
   localparam int LAT      = NEURONS + 1;
   localparam int DEPTH    = NEURONS << IN_BITS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lut_layer_engine_if #(
      .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS)
   ) bus ();

   lut_layer_engine #(
      .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   // model: table image, transaction phase, expected vectors
   logic [OUT_BITS-1:0] tbl [DEPTH];
   int         phase = 0;
   int         cnt   = 0;
   logic [3:0] mdl_exp   = '0;
   logic [3:0] mdl_mdata = '0;
   int         acc_q [$];
   logic [3:0] out_q [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] calc(input logic [31:0] d);
      logic [3:0] r;
      r = '0;
      for (int n = 0; n < NEURONS; n++)
         r[n] = tbl[n * 256 + int'(d[n*IN_BITS +: IN_BITS])];
      return r;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         case (phase)
            0: begin
               chk("idle_cfg_ready", bus.cfg_ready, 1);
               chk("idle_s_ready", bus.s_ready, !bus.cfg_we);
               chk("idle_busy", bus.busy, 0);
               chk("idle_m_valid", bus.m_valid, 0);
               chk("idle_m_data", bus.m_data, mdl_mdata);
            end
            1: begin
               chk("eval_cfg_ready", bus.cfg_ready, 0);
               chk("eval_s_ready", bus.s_ready, 0);
               chk("eval_busy", bus.busy, 1);
               chk("eval_m_valid", bus.m_valid, 0);
            end
            default: begin
               chk("hold_cfg_ready", bus.cfg_ready, 0);
               chk("hold_s_ready", bus.s_ready, 0);
               chk("hold_busy", bus.busy, 1);
               chk("hold_m_valid", bus.m_valid, 1);
               chk("hold_m_data", bus.m_data, mdl_exp);
            end
         endcase
      end
      case (phase)
         0: begin
            if (bus.cfg_we) begin
               tbl[bus.cfg_addr] = bus.cfg_data;
            end else if (bus.s_valid) begin
               mdl_exp = calc(bus.s_data);
               phase = 1;
               cnt = 1;
               if (rst) acc_q.push_back(cyc + 1);
            end
         end
         1: begin
            if (cnt == LAT) begin
               phase = 2;
               mdl_mdata = mdl_exp;
            end else begin
               cnt++;
            end
         end
         default: begin
            if (bus.m_ready) begin
               if (rst) out_q.push_back(bus.m_data);
               phase = 0;
            end
         end
      endcase
      if (!rst) begin
         phase = 0;
         mdl_mdata = '0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, output int t0);
      int ok;
      ok = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      for (int i = 0; i < 50 && ok == 0; i++) begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) ok = 1;
         step();
      end
      bus.s_valid = 1'b0;
      t0 = cyc;
      chk("send_accept", ok, 1);
   endtask

   task automatic wait_valid(input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         @(negedge clk);
         if (bus.m_valid === 1'b1) lat = cyc - t0;
      end
      chk("m_valid_latency", lat, LAT);
   endtask

   task automatic cfg_write(input logic [9:0] a, input logic d);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_data = d;
      step();
      bus.cfg_we = 1'b0;
   endtask

   initial begin
      int t0, lat, k, rdy, n_out, seen_v;
      logic [31:0] vv [3];
      logic [3:0]  ve [3];
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_cfg_ready", bus.cfg_ready, 1);
      step();

      // neuron n table: entry = bit (5-n) of the pattern
      for (int n = 0; n < NEURONS; n++)
         for (int p = 0; p < 256; p++) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 10'(n * 256 + p);
            bus.cfg_data = 1'((p >> (5 - n)) & 1);
            step();
         end
      bus.cfg_we = 1'b0;

      // basic evaluation
      send(32'h08_04_02_20, t0);
      chk("t1_model_pin", mdl_exp, 4'b0001);
      wait_valid(t0, lat);
      chk("t1_m_data", bus.m_data, 4'b0001);
      step();

      // backpressure
      bus.m_ready = 1'b0;
      send(32'h08_04_02_20, t0);
      wait_valid(t0, lat);
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         chk("bp_m_data", bus.m_data, 4'b0001);
         chk("bp_s_ready", bus.s_ready, 0);
         chk("bp_busy", bus.busy, 1);
      end
      step();
      bus.m_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_release_s_ready", bus.s_ready, 1);
      chk("bp_release_m_valid", bus.m_valid, 0);
      step();

      // config/input collision
      bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = 1'b1;
      bus.s_valid = 1'b1; bus.s_data = 32'h0;
      @(negedge clk);
      chk("col_s_ready", bus.s_ready, 0);
      step();
      bus.cfg_we = 1'b0;
      @(negedge clk);
      chk("col_s_ready_next", bus.s_ready, 1);
      step();
      bus.s_valid = 1'b0;
      t0 = cyc;
      wait_valid(t0, lat);
      chk("col_m_data", bus.m_data, 4'b0001);
      step();

      // config during EVAL is dropped
      cfg_write(10'h020, 1'b0);
      send(32'h08_04_02_20, t0);
      step();
      bus.cfg_we = 1'b1; bus.cfg_addr = 10'h020; bus.cfg_data = 1'b1;
      @(negedge clk);
      chk("eval_cfg_blocked", bus.cfg_ready, 0);
      step();
      bus.cfg_we = 1'b0;
      wait_valid(t0, lat);
      chk("t4_m_data", bus.m_data, 4'b0000);
      step();
      send(32'h08_04_02_20, t0);
      wait_valid(t0, lat);
      chk("t4_ignored", bus.m_data, 4'b0000);
      step();
      cfg_write(10'h020, 1'b1);

      // reset mid-EVAL
      send(32'h08_04_02_20, t0);
      step();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_valid", bus.m_valid, 0);
      chk("mid_rst_m_data", bus.m_data, 0);
      chk("mid_rst_busy", bus.busy, 0);
      n_out = out_q.size();
      seen_v = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (bus.m_valid === 1'b1) seen_v = 1;
      end
      chk("mid_rst_no_valid", seen_v, 0);
      chk("mid_rst_no_output", out_q.size(), n_out);
      step();
      send(32'h08_04_02_20, t0);
      wait_valid(t0, lat);
      chk("mid_rst_resend", bus.m_data, 4'b0001);
      step();

      // back-to-back
      vv[0] = 32'h08_04_02_20; ve[0] = 4'b0001;
      vv[1] = 32'h04_08_10_01; ve[1] = 4'b1110;
      vv[2] = 32'h00_FF_00_DF; ve[2] = 4'b0100;
      acc_q.delete();
      out_q.delete();
      k = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = vv[0];
      for (int i = 0; i < 100 && k < 3; i++) begin
         @(negedge clk);
         rdy = int'(bus.s_ready === 1'b1);
         step();
         if (rdy != 0) begin
            k++;
            if (k < 3) bus.s_data = vv[k];
            else bus.s_valid = 1'b0;
         end
      end
      chk("b2b_all_accepted", k, 3);
      for (int i = 0; i < 40 && out_q.size() < 3; i++) step();
      chk("b2b_out_count", out_q.size(), 3);
      if (out_q.size() == 3 && acc_q.size() == 3) begin
         for (int i = 0; i < 3; i++)
            chk("b2b_order", out_q[i], ve[i]);
         for (int i = 1; i < 3; i++)
            chk("b2b_spacing", acc_q[i] - acc_q[i-1], LAT + 2);
      end

      // randomized traffic, occasional reset
      for (int i = 0; i < 1000; i++) begin
         bus.cfg_we   = ($urandom_range(0, 7) == 0);
         bus.cfg_addr = 10'($urandom);
         bus.cfg_data = 1'($urandom);
         bus.s_valid  = 1'($urandom);
         bus.s_data   = $urandom;
         bus.m_ready  = ($urandom_range(0, 9) < 6);
         rst          = ($urandom_range(0, 79) != 0);
         step();
      end
      rst = 1'b1;
      bus.cfg_we = 1'b0;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      repeat (12) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
